// File: rtl/acc_alu_seq.sv
// Sequential execute stage feeding an N-bit load/store accumulator register.
// Latency: non-MUL result strobed 2 cycles after start is sampled; MUL after N+2 cycles.
// Backpressure: start is accepted only in IDLE; a start seen while busy is dropped, not queued.
//
// Ports:
//   clk, clr        rising-edge clock, synchronous active-high reset
//   start, op       operation request and opcode (sampled only in IDLE)
//   acc_in, opd     accumulator value and operand, captured with start
//   busy            high whenever the FSM is not in IDLE
//   acc_ld          one-cycle load strobe to the accumulator's ld_str input
//   acc_d           result, held between operations
//   carry, zero     flags of the last completed operation
module acc_alu_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] acc_in,
  input  logic [N-1:0] opd,
  output logic         busy,
  output logic         acc_ld,
  output logic [N-1:0] acc_d,
  output logic         carry,
  output logic         zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WRITE} state_t;

  state_t         state, state_nxt;
  logic [2:0]     op_q;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] prod;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   alu_res;
  logic           alu_cy;
  logic [N:0]     sum;
  logic [N:0]     mul_hi;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (op == 3'b111) ? MUL : EXEC;
      EXEC:    state_nxt = WRITE;
      // The step counter reaching N means all N shift-add steps are done;
      // that extra cycle is spent deciding, not stepping.
      MUL:     if (cnt == CW'(N)) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result/flag selection. The MUL case reads the finished product register,
  // so WRITE entry loads acc_d from the same mux on both paths.
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    case (op_q)
      3'b000: alu_res = b_q;
      3'b001: begin
        alu_res = sum[N-1:0];
        alu_cy  = sum[N];
      end
      3'b010: begin
        alu_res = a_q - b_q;
        alu_cy  = (a_q >= b_q);
      end
      3'b011: alu_res = a_q & b_q;
      3'b100: alu_res = a_q | b_q;
      3'b101: alu_res = ~a_q;
      3'b110: begin
        alu_res = {a_q[N-2:0], 1'b0};
        alu_cy  = a_q[N-1];
      end
      default: begin
        alu_res = prod[N-1:0];
        alu_cy  = |prod[2*N-1:N];
      end
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, keep the carry, then shift right by one.
  always_comb begin
    mul_hi = {1'b0, prod[2*N-1:N]} + (prod[0] ? {1'b0, b_q} : {(N+1){1'b0}});
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (clr) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      acc_ld <= 1'b0;
      acc_d  <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
    end else begin
      busy   <= (state_nxt != IDLE);
      acc_ld <= (state_nxt == WRITE);

      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= acc_in;
            b_q  <= opd;
            prod <= {{N{1'b0}}, acc_in};
            cnt  <= '0;
          end
        end
        MUL: begin
          if (cnt != CW'(N)) begin
            prod <= {mul_hi, prod[N-1:1]};
            cnt  <= cnt + 1'b1;
          end
        end
        default: ;
      endcase

      if (state_nxt == WRITE) begin
        acc_d <= alu_res;
        carry <= alu_cy;
        zero  <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed self-checking bench for acc_alu_seq (N=8).
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Each check is an immediate assertion; failures are counted and reported.
module tb_acc_alu_seq;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] acc_in;
  logic [N-1:0] opd;
  logic         busy;
  logic         acc_ld;
  logic [N-1:0] acc_d;
  logic         carry;
  logic         zero;

  int vectors  = 0;
  int mismatch = 0;

  acc_alu_seq #(.N(N)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .op     (op),
    .acc_in (acc_in),
    .opd    (opd),
    .busy   (busy),
    .acc_ld (acc_ld),
    .acc_d  (acc_d),
    .carry  (carry),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      mismatch++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it to completion. lat counts falling edges
  // after the start-sampling edge until acc_ld is seen; bcnt counts busy cycles.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [N-1:0] a,
                        input logic [N-1:0] b, input logic [N-1:0] exp_d,
                        input logic exp_c, input logic exp_z, input int exp_lat,
                        input int exp_busy);
    int lat;
    int bcnt;
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; acc_in = a; opd = b;
    @(negedge clk);
    // Scramble inputs after the start edge; the op must not see this.
    start = 1'b0; op = 3'b000; acc_in = 8'h5C; opd = 8'hC5;
    lat = 1;
    while (!acc_ld && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    chk({tag, "_lat"},   16'(lat), 16'(exp_lat));
    chk({tag, "_acc_d"}, 16'(acc_d), 16'(exp_d));
    chk({tag, "_carry"}, 16'(carry), 16'(exp_c));
    chk({tag, "_zero"},  16'(zero), 16'(exp_z));
    if (exp_busy > 0) chk({tag, "_busy_cycles"}, 16'(bcnt), 16'(exp_busy));
    @(negedge clk);
    chk({tag, "_ld_one_cycle"}, 16'(acc_ld), 16'd0);
    chk({tag, "_busy_done"},    16'(busy), 16'd0);
  endtask

  initial begin
    int pulses;
    int idx [$];
    clr = 1'b1; start = 1'b0; op = '0; acc_in = '0; opd = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",   16'(busy),   16'd0);
    chk("rst_acc_ld", 16'(acc_ld), 16'd0);
    chk("rst_acc_d",  16'(acc_d),  16'd0);
    chk("rst_carry",  16'(carry),  16'd0);
    chk("rst_zero",   16'(zero),   16'd0);
    clr = 1'b0;

    // Arithmetic
    run_op("add_f0_20", 3'b001, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 2, 2);
    run_op("sub_05_05", 3'b010, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 2, 0);
    run_op("sub_03_05", 3'b010, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 2, 0);
    run_op("mul_0c_0b", 3'b111, 8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, N + 2, N + 2);
    run_op("mul_20_10", 3'b111, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, N + 2, 0);

    // clr held two cycles mid-MUL aborts without a load strobe
    @(negedge clk);
    start = 1'b1; op = 3'b111; acc_in = 8'h07; opd = 8'h09;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (acc_ld) pulses++;
      @(negedge clk);
    end
    chk("abort_no_ld", 16'(pulses), 16'd0);
    chk("abort_busy",  16'(busy),   16'd0);
    chk("abort_acc_d", 16'(acc_d),  16'd0);
    chk("abort_carry", 16'(carry),  16'd0);
    chk("abort_zero",  16'(zero),   16'd0);

    // start re-pulsed while a MUL is running is ignored
    start = 1'b1; op = 3'b111; acc_in = 8'h03; opd = 8'h05;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = 3'b000; opd = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      if (acc_ld) pulses++;
      @(negedge clk);
    end
    chk("busy_start_one_ld", 16'(pulses), 16'd1);
    chk("busy_start_acc_d",  16'(acc_d),  16'h0F);

    // start and clr together: clr wins, FSM stays IDLE
    start = 1'b1; clr = 1'b1; op = 3'b001; acc_in = 8'h11; opd = 8'h22;
    @(negedge clk);
    chk("start_clr_busy",  16'(busy),  16'd0);
    chk("start_clr_acc_d", 16'(acc_d), 16'd0);
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk("start_clr_idle", 16'(busy), 16'd0);

    // Shift and invert
    run_op("shl_81", 3'b110, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 2, 0);
    run_op("not_ff", 3'b101, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 2, 0);

    // start held high with PASS: a new op every time the FSM returns to IDLE
    @(negedge clk);
    start = 1'b1; op = 3'b000; acc_in = 8'h00; opd = 8'h5A;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (acc_ld) idx.push_back(i);
    end
    start = 1'b0;
    chk("b2b_pulse_count", 16'(idx.size()), 16'd4);
    if (idx.size() >= 3) begin
      chk("b2b_first_at", 16'(idx[0]), 16'd2);
      chk("b2b_gap0", 16'(idx[1] - idx[0]), 16'd3);
      chk("b2b_gap1", 16'(idx[2] - idx[1]), 16'd3);
    end
    chk("b2b_acc_d", 16'(acc_d), 16'h5A);
    repeat (3) @(negedge clk);
    chk("b2b_stop_busy", 16'(busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, mismatch);
    $finish;
  end

endmodule
